// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and write-back bypass.
// Holds one decoded instruction for the execute stage.
module id_ex_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InValid,
    input  logic [4:0]  InRs1,
    input  logic [4:0]  InRs2,
    input  logic [4:0]  InRd,
    input  logic [31:0] InImm,
    input  logic        InRegWrite,
    input  logic        InMemRead,
    input  logic        InMemWrite,
    input  logic        InAluSrc,
    input  logic [3:0]  InAluOp,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic        WbEn,
    input  logic [4:0]  WbAddr,
    input  logic [31:0] WbData,
    input  logic        Stall,
    input  logic        Flush,
    output logic        HazardStall,
    output logic        ExValid,
    output logic [4:0]  ExRs1,
    output logic [4:0]  ExRs2,
    output logic [4:0]  ExRd,
    output logic [31:0] ExRs1Val,
    output logic [31:0] ExRs2Val,
    output logic [31:0] ExImm,
    output logic        ExRegWrite,
    output logic        ExMemRead,
    output logic        ExMemWrite,
    output logic        ExAluSrc,
    output logic [3:0]  ExAluOp,
    output logic [15:0] BubbleCount
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic [3:0]  alu_op;
    } ex_bundle_t;

    ex_bundle_t  ex_q, ex_d;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic [31:0] op1, op2;

    // Register-file writes land at the same edge as capture, so a matching
    // write-back value is newer than the combinational read data.
    always_comb begin
        op1 = ReadData1;
        if (InRs1 == 5'd0) begin
            op1 = 32'd0;
        end else if (BYPASS_EN && WbEn && (WbAddr == InRs1)) begin
            op1 = WbData;
        end
        op2 = ReadData2;
        if (InRs2 == 5'd0) begin
            op2 = 32'd0;
        end else if (BYPASS_EN && WbEn && (WbAddr == InRs2)) begin
            op2 = WbData;
        end
    end

    // A load in execute cannot supply its result to the instruction right behind it.
    assign HazardStall = InValid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                         ((ex_q.rd == InRs1) | (ex_q.rd == InRs2));

    // InValid qualifies the decode bundle; Stall holds this stage, Flush squashes it,
    // and HazardStall tells decode/fetch to re-present the same instruction next cycle.
    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (Flush) begin
            ex_d = '0;
        end else if (!Stall) begin
            if (HazardStall) begin
                ex_d = '0;
                if (bubble_count_q != 16'hFFFF) begin
                    bubble_count_d = bubble_count_q + 16'd1;
                end
            end else if (InValid) begin
                ex_d.valid     = 1'b1;
                ex_d.rs1       = InRs1;
                ex_d.rs2       = InRs2;
                ex_d.rd        = InRd;
                ex_d.rs1_val   = op1;
                ex_d.rs2_val   = op2;
                ex_d.imm       = InImm;
                ex_d.reg_write = InRegWrite;
                ex_d.mem_read  = InMemRead;
                ex_d.mem_write = InMemWrite;
                ex_d.alu_src   = InAluSrc;
                ex_d.alu_op    = InAluOp;
            end else begin
                ex_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q           <= '0;
            bubble_count_q <= 16'd0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ExValid     = ex_q.valid;
    assign ExRs1       = ex_q.rs1;
    assign ExRs2       = ex_q.rs2;
    assign ExRd        = ex_q.rd;
    assign ExRs1Val    = ex_q.rs1_val;
    assign ExRs2Val    = ex_q.rs2_val;
    assign ExImm       = ex_q.imm;
    assign ExRegWrite  = ex_q.reg_write;
    assign ExMemRead   = ex_q.mem_read;
    assign ExMemWrite  = ex_q.mem_write;
    assign ExAluSrc    = ex_q.alu_src;
    assign ExAluOp     = ex_q.alu_op;
    assign BubbleCount = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, with the
// bypassing (index 0) and non-bypassing (index 1) variants run side by side.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
        logic [3:0]  op;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_reg_write, in_mem_read, in_mem_write, in_alu_src;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_addr;
    logic [31:0] in_imm, read_data1, read_data2, wb_data;
    logic [3:0]  in_alu_op;
    logic        wb_en, stall, flush;

    logic        hz [2];
    logic        ex_valid [2];
    logic [4:0]  ex_rs1 [2];
    logic [4:0]  ex_rs2 [2];
    logic [4:0]  ex_rd [2];
    logic [31:0] ex_rs1_val [2];
    logic [31:0] ex_rs2_val [2];
    logic [31:0] ex_imm [2];
    logic        ex_reg_write [2];
    logic        ex_mem_read [2];
    logic        ex_mem_write [2];
    logic        ex_alu_src [2];
    logic [3:0]  ex_alu_op [2];
    logic [15:0] bubble_count [2];

    ex_t         m [2];
    logic [15:0] mbc [2];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .InValid(in_valid), .InRs1(in_rs1), .InRs2(in_rs2), .InRd(in_rd),
        .InImm(in_imm), .InRegWrite(in_reg_write), .InMemRead(in_mem_read),
        .InMemWrite(in_mem_write), .InAluSrc(in_alu_src), .InAluOp(in_alu_op),
        .ReadData1(read_data1), .ReadData2(read_data2), .WbEn(wb_en), .WbAddr(wb_addr),
        .WbData(wb_data), .Stall(stall), .Flush(flush), .HazardStall(hz[0]),
        .ExValid(ex_valid[0]), .ExRs1(ex_rs1[0]), .ExRs2(ex_rs2[0]), .ExRd(ex_rd[0]),
        .ExRs1Val(ex_rs1_val[0]), .ExRs2Val(ex_rs2_val[0]), .ExImm(ex_imm[0]),
        .ExRegWrite(ex_reg_write[0]), .ExMemRead(ex_mem_read[0]), .ExMemWrite(ex_mem_write[0]),
        .ExAluSrc(ex_alu_src[0]), .ExAluOp(ex_alu_op[0]), .BubbleCount(bubble_count[0])
    );

    id_ex_stage #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .InValid(in_valid), .InRs1(in_rs1), .InRs2(in_rs2), .InRd(in_rd),
        .InImm(in_imm), .InRegWrite(in_reg_write), .InMemRead(in_mem_read),
        .InMemWrite(in_mem_write), .InAluSrc(in_alu_src), .InAluOp(in_alu_op),
        .ReadData1(read_data1), .ReadData2(read_data2), .WbEn(wb_en), .WbAddr(wb_addr),
        .WbData(wb_data), .Stall(stall), .Flush(flush), .HazardStall(hz[1]),
        .ExValid(ex_valid[1]), .ExRs1(ex_rs1[1]), .ExRs2(ex_rs2[1]), .ExRd(ex_rd[1]),
        .ExRs1Val(ex_rs1_val[1]), .ExRs2Val(ex_rs2_val[1]), .ExImm(ex_imm[1]),
        .ExRegWrite(ex_reg_write[1]), .ExMemRead(ex_mem_read[1]), .ExMemWrite(ex_mem_write[1]),
        .ExAluSrc(ex_alu_src[1]), .ExAluOp(ex_alu_op[1]), .BubbleCount(bubble_count[1])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ex_t obs(input int i);
        ex_t o;
        o = '{ex_valid[i], ex_rs1[i], ex_rs2[i], ex_rd[i], ex_rs1_val[i], ex_rs2_val[i],
              ex_imm[i], ex_reg_write[i], ex_mem_read[i], ex_mem_write[i], ex_alu_src[i],
              ex_alu_op[i]};
        return o;
    endfunction

    // Operand as the execute stage should see it: x0 is zero, a same-cycle
    // write to the register wins when bypassing is built in.
    function automatic logic [31:0] operand(input int i, input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (i == 0 && wb_en && wb_addr == a) return wb_data;
        return rf;
    endfunction

    function automatic logic model_hazard(input int i);
        return in_valid && m[i].valid && m[i].mr && (m[i].rd != 5'd0) &&
               (m[i].rd == in_rs1 || m[i].rd == in_rs2);
    endfunction

    task automatic model_step(input int i);
        logic h;
        h = model_hazard(i);
        if (flush) begin
            m[i] = '0;
        end else if (!stall) begin
            if (h) begin
                m[i] = '0;
                if (mbc[i] < 16'hFFFF) mbc[i] = mbc[i] + 16'd1;
            end else if (!in_valid) begin
                m[i] = '0;
            end else begin
                m[i] = '{1'b1, in_rs1, in_rs2, in_rd, operand(i, in_rs1, read_data1),
                         operand(i, in_rs2, read_data2), in_imm, in_reg_write, in_mem_read,
                         in_mem_write, in_alu_src, in_alu_op};
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i]   = '0;
            mbc[i] = 16'd0;
        end
    endtask

    // Entered just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("hazard%0d", i), 128'(hz[i]), 128'(model_hazard(i)));
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bundle%0d", i), 128'(obs(i)), 128'(m[i]));
            check($sformatf("bubbles%0d", i), 128'(bubble_count[i]), 128'(mbc[i]));
        end
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0;
        in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_alu_src = 0; in_alu_op = 0;
        read_data1 = 0; read_data2 = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        stall = 0; flush = 0;
    endtask

    task automatic drive_random();
        in_valid     = ($urandom_range(0, 3) != 0);
        in_rs1       = 5'($urandom_range(0, 7));
        in_rs2       = 5'($urandom_range(0, 7));
        in_rd        = 5'($urandom_range(0, 7));
        in_imm       = $urandom;
        in_reg_write = 1'($urandom_range(0, 1));
        in_mem_read  = 1'($urandom_range(0, 1));
        in_mem_write = 1'($urandom_range(0, 1));
        in_alu_src   = 1'($urandom_range(0, 1));
        in_alu_op    = 4'($urandom_range(0, 15));
        read_data1   = $urandom;
        read_data2   = $urandom;
        wb_en        = 1'($urandom_range(0, 1));
        wb_addr      = 5'($urandom_range(0, 7));
        wb_data      = $urandom;
        stall        = ($urandom_range(0, 7) == 0);
        flush        = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        ex_t snap;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_bundle", 128'(obs(i)), 128'(m[i]));
            check("reset_bubbles", 128'(bubble_count[i]), 128'd0);
            check("reset_hazard", 128'(hz[i]), 128'd0);
        end
        rst = 1'b0;

        // Plain capture.
        in_valid = 1; in_rs1 = 2; in_rs2 = 3; read_data1 = 13; read_data2 = 28; in_alu_op = 4'h2;
        cycle();
        check("cap_valid", 128'(ex_valid[0]), 128'd1);
        check("cap_rs1val", 128'(ex_rs1_val[0]), 128'd13);
        check("cap_rs2val", 128'(ex_rs2_val[0]), 128'd28);
        check("cap_aluop", 128'(ex_alu_op[0]), 128'd2);

        // Bypass from write-back, then x0.
        wb_en = 1; wb_addr = 2; wb_data = 32'h55;
        cycle();
        check("byp_on", 128'(ex_rs1_val[0]), 128'h55);
        check("byp_off", 128'(ex_rs1_val[1]), 128'd13);
        in_rs1 = 0;
        cycle();
        check("x0_on", 128'(ex_rs1_val[0]), 128'd0);
        check("x0_off", 128'(ex_rs1_val[1]), 128'd0);
        wb_en = 0;

        // Load-use: load to r5, then a consumer of r5.
        in_rs1 = 1; in_rs2 = 1; in_rd = 5; in_mem_read = 1;
        cycle();
        in_rs1 = 7; in_rs2 = 5; in_rd = 6; in_mem_read = 0;
        #1;
        check("lu_hazard", 128'(hz[0]), 128'd1);
        cycle();
        check("lu_bubble", 128'(ex_valid[0]), 128'd0);
        check("lu_count", 128'(bubble_count[0]), 128'd1);
        cycle();
        check("lu_resume", 128'(ex_valid[0]), 128'd1);
        check("lu_rd", 128'(ex_rd[0]), 128'd6);

        // Flush beats Stall; Stall alone holds everything.
        flush = 1; stall = 1;
        cycle();
        check("flush_stall", 128'(ex_valid[0]), 128'd0);
        flush = 0; stall = 0; in_rs1 = 3; in_rs2 = 4; in_imm = 32'hDEAD_BEEF;
        cycle();
        snap = m[0];
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            drive_random();
            stall = 1; flush = 0;
            cycle();
            check("stall_hold", 128'(obs(0)), 128'(snap));
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            cycle();
        end

        // Saturation: preload the counter close to the top, then add real bubbles.
        clear_inputs();
        force dut.bubble_count_q = 16'hFFFD;
        force dut_nb.bubble_count_q = 16'hFFFD;
        #1;
        release dut.bubble_count_q;
        release dut_nb.bubble_count_q;
        mbc[0] = 16'hFFFD;
        mbc[1] = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            in_valid = 1; in_mem_read = 1; in_rd = 9;
            cycle();
            in_mem_read = 0; in_rd = 1; in_rs1 = 9;
            cycle();
        end
        check("sat0", 128'(bubble_count[0]), 128'hFFFF);
        check("sat1", 128'(bubble_count[1]), 128'hFFFF);

        // Asynchronous reset between edges, released while stalled.
        clear_inputs();
        in_valid = 1; in_rs1 = 4; read_data1 = 32'h77;
        cycle();
        check("pre_rst_valid", 128'(ex_valid[0]), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("arst_valid", 128'(ex_valid[i]), 128'd0);
            check("arst_bubbles", 128'(bubble_count[i]), 128'd0);
            check("arst_hazard", 128'(hz[i]), 128'd0);
        end
        stall = 1;
        @(posedge clk);
        @(negedge clk);
        check("rst_held", 128'(obs(0)), 128'(m[0]));
        rst = 1'b0;
        cycle();
        stall = 0;
        cycle();
        check("post_rst_cap", 128'(ex_rs1_val[0]), 128'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
